rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 32: number of 32-bit ROM words.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width of both requesters.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: request present (port 0 = instruction fetch, port 1 = data load).
REQ-006 SHALL have ports req0_addr / req1_addr, input, ADDR_W each: byte address.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each: request accepted this cycle when valid && ready.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each: response present.
REQ-009 SHALL have ports rsp0_ready / rsp1_ready, input, 1 each: response consumed when valid && ready.
REQ-010 SHALL have ports rsp0_data / rsp1_data, output, 32 each: read word.
REQ-011 SHALL have ports rsp0_err / rsp1_err, output, 1 each: access fault.
REQ-012 SHALL have port rom_addr, output, ADDR_W: registered byte address driven to the combinational word-indexed ROM.
REQ-013 SHALL have port rom_data, input, 32: combinational ROM read data for rom_addr.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-015 SHALL, in IDLE, select one of the valid requesters, assert only that port's ready combinationally, and go to ACCESS on the accepting edge.
REQ-016 SHALL arbitrate round-robin: a tie goes to the port not granted last; a lone valid requester always wins.
REQ-017 SHALL hold ready low on both ports in ACCESS and RESP.
REQ-018 SHALL register the accepted address into rom_addr on the accepting edge and hold it until the next acceptance.
REQ-019 SHALL capture rom_data into the granted port's rsp_data at the end of ACCESS, then go to RESP.
REQ-020 SHALL assert the granted port's rsp_valid throughout RESP (2 cycles after the accepting edge); the other port's rsp_valid stays 0.
REQ-021 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready; on valid && ready, drop rsp_valid and return to IDLE.
REQ-022 SHALL keep rsp_valid asserted indefinitely while rsp_ready = 0; no timeout.
REQ-023 SHALL set rsp_err = 1 and rsp_data = 0 when addr[1:0] != 0 or addr[ADDR_W-1:2] >= ROM_SIZE; latency is unchanged.
REQ-024 SHALL fix the accept-to-accept period at a minimum of 3 cycles (IDLE, ACCESS, RESP with rsp_ready = 1).
REQ-025 SHALL update the last-granted port only on acceptance.
REQ-026 SHALL ignore a deassertion of req_valid by a requester that is not ready (no accept, no state change).

Reset
REQ-027 SHALL, when rst_n = 0 at a clock edge, force the state to IDLE, both rsp_valid to 0, both rsp_data to 0, both rsp_err to 0, rom_addr to 0, and last-grant to port 1 (port 0 wins the first tie).
REQ-028 SHALL hold req0_ready and req1_ready at 0 while rst_n = 0.
REQ-029 SHALL discard an in-flight transaction when reset is applied in ACCESS or RESP, with no response delivered after reset.

Structure
REQ-030 SHALL place the state enum (IDLE/ACCESS/RESP) and the port index constants (PORT_IF = 0, PORT_LD = 1) in shared package rom_arb_pkg.
REQ-031 SHALL implement the two-way round-robin pick as sub-module rom_rr_pick (inputs: valid[1:0], last; output: grant index).

Verification
REQ-032 Single request: req0 addr 0x00000008, ROM word 2 = 0xDEADBEEF -> req0_ready in cycle 0; rsp0_valid in cycle 2 with data 0xDEADBEEF, err 0.
REQ-033 Tie after reset: both valid (req0 0x4, req1 0xC) held -> port 0 served first, then port 1; the next tie goes to port 0 again.
REQ-034 Misaligned: req1 addr 0x00000006 -> rsp1_err 1, data 0 at cycle 2.
REQ-035 Out of range: req0 addr 0x00000080 (word 32, ROM_SIZE 32) -> rsp0_err 1.
REQ-036 Backpressure: rsp0_ready 0 for 5 cycles -> rsp0_valid and data stable, both ready outputs 0 throughout; accept resumes the cycle after rsp0_ready.
REQ-037 Reset in ACCESS: rst_n low 1 cycle -> no rsp_valid afterwards, rom_addr 0, port 0 wins the next tie.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared FSM state type and port indices for the ROM port arbiter
package rom_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LD = 1'b1;
endpackage

// File: rtl/rom_rr_pick.sv
// rom_rr_pick: two-way round-robin pick, a tie goes to the port not granted last
module rom_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);
  always_comb grant = (valid == 2'b11) ? ~last : (valid[1] & ~valid[0]);
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin arbiter sharing one combinational ROM between fetch and load ports
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_SIZE = 32,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_data,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_data,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data
);
  state_t      state;
  logic        last, gnt, pick, acc, fault, rsp_ready_g;
  logic [1:0]  rv, re;
  logic [31:0] rd [2];
  logic [ADDR_W-1:0] addr_sel;
  rom_rr_pick u_pick (.valid({req1_valid, req0_valid}), .last(last), .grant(pick));
  always_comb begin
    acc         = rst_n && state == IDLE && (req0_valid || req1_valid);
    req0_ready  = acc && pick == PORT_IF;
    req1_ready  = acc && pick == PORT_LD;
    addr_sel    = pick ? req1_addr : req0_addr;
    rsp_ready_g = gnt ? rsp1_ready : rsp0_ready;
    fault       = |rom_addr[1:0] || (rom_addr >> 2) >= ADDR_W'(ROM_SIZE);
  end
  assign {rsp1_valid, rsp0_valid} = rv;
  assign {rsp1_err, rsp0_err}     = re;
  assign rsp0_data = rd[0];
  assign rsp1_data = rd[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rv       <= '0;
      re       <= '0;
      rd[0]    <= '0;
      rd[1]    <= '0;
      rom_addr <= '0;
      last     <= PORT_LD;
      gnt      <= PORT_IF;
    end else begin
      case (state)
        IDLE: if (acc) begin
          rom_addr <= addr_sel;
          gnt      <= pick;
          last     <= pick;
          state    <= ACCESS;
        end
        ACCESS: begin
          rd[gnt] <= fault ? 32'd0 : rom_data;
          re[gnt] <= fault;
          rv[gnt] <= 1'b1;
          state   <= RESP;
        end
        RESP: if (rsp_ready_g) begin
          rv[gnt] <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench with directed cases and randomized traffic
module tb_rom_port_arbiter;
  localparam int ROM_SIZE = 32;
  localparam int ADDR_W   = 32;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr = 0, req1_addr = 0, rom_addr;
  logic rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic rsp0_ready = 1, rsp1_ready = 1;
  logic [31:0] rsp0_data, rsp1_data, rom_data;
  logic [31:0] mem [ROM_SIZE];
  typedef struct {bit port; logic [31:0] data; bit err; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit last_g = 1, prev_rv = 0, post_rst = 0;

  rom_port_arbiter #(.ROM_SIZE(ROM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // out-of-range words return junk so the arbiter must zero them itself
  always_comb rom_data = ((rom_addr >> 2) < ROM_SIZE) ? mem[rom_addr[6:2]] : 32'hA5A5_5A5A;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(bit p, logic [31:0] a);
    exp_t e;
    e.port = p;
    e.err  = (a % 4 != 0) || (a / 4 >= ROM_SIZE);
    e.data = e.err ? 32'd0 : mem[a / 4];
    e.cyc  = cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    bit ep, any, hs;
    logic [1:0] v;
    exp_t e;
    v = {req1_valid, req0_valid};
    if (!rst_n) begin
      chk("ready_in_reset", {req1_ready, req0_ready}, 0);
      q.delete();
      last_g = 1;
      prev_rv = 0;
      post_rst = 1;
    end else begin
      if (post_rst) begin
        chk("rsp_valid_after_reset", {rsp1_valid, rsp0_valid}, 0);
        chk("rom_addr_after_reset", rom_addr, 0);
        post_rst = 0;
      end
      ep  = (v == 2'b11) ? !last_g : v[1];
      any = q.size() == 0 && v != 0;
      chk("req0_ready", req0_ready, any && !ep);
      chk("req1_ready", req1_ready, any && ep);
      if (rsp0_valid || rsp1_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", {rsp1_valid, rsp0_valid}, 0);
        else begin
          e = q[0];
          chk("rsp_port", {rsp1_valid, rsp0_valid}, e.port ? 2'b10 : 2'b01);
          chk("rsp_data", e.port ? rsp1_data : rsp0_data, e.data);
          chk("rsp_err", e.port ? rsp1_err : rsp0_err, e.err);
          if (!prev_rv) chk("rsp_latency", cyc - e.cyc, 2);
          hs = e.port ? rsp1_ready : rsp0_ready;
          prev_rv = !hs;
          if (hs) void'(q.pop_front());
        end
      end else begin
        prev_rv = 0;
        if (q.size() != 0 && cyc - q[0].cyc >= 2)
          chk("rsp_missing", {rsp1_valid, rsp0_valid}, q[0].port ? 2'b10 : 2'b01);
      end
      if (any && (req0_ready || req1_ready)) begin
        q.push_back(model(ep, ep ? req1_addr : req0_addr));
        last_g = ep;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(bit p, logic [31:0] a);
    bit done = 0;
    if (p) begin req1_valid = 1; req1_addr = a; end
    else begin req0_valid = 1; req0_addr = a; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = p ? req1_ready : req0_ready;
    end
    if (!done) chk("issue_timeout", p ? req1_ready : req0_ready, 1);
    tick();
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1: rand_addr = {25'd0, 5'($urandom_range(0, ROM_SIZE - 1)), 2'b00};
      2:    rand_addr = {25'd0, 5'($urandom), 2'($urandom_range(1, 3))};
      default: rand_addr = $urandom_range(ROM_SIZE, 4 * ROM_SIZE) * 4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < ROM_SIZE; i++) mem[i] = $urandom;
    mem[2] = 32'hDEAD_BEEF;
    tick(3);
    rst_n = 1;
    issue(0, 32'h8);
    tick(3);
    req0_valid = 1; req0_addr = 32'h4;
    req1_valid = 1; req1_addr = 32'hC;
    tick(9);
    req0_valid = 0; req1_valid = 0;
    tick(3);
    issue(1, 32'h6);
    tick(3);
    issue(0, 32'h80);
    tick(3);
    rsp0_ready = 0;
    issue(0, 32'h10);
    req1_valid = 1; req1_addr = 32'h14;
    tick(5);
    rsp0_ready = 1;
    issue(1, 32'h14);
    tick(3);
    issue(0, 32'h18);
    rst_n = 0;
    tick();
    rst_n = 1;
    req0_valid = 1; req0_addr = 32'h1C;
    req1_valid = 1; req1_addr = 32'h20;
    tick(3);
    req0_valid = 0; req1_valid = 0;
    tick(3);
    repeat (3000) begin
      rst_n      = $urandom_range(0, 299) != 0;
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      req0_addr  = rand_addr();
      req1_addr  = rand_addr();
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    tick(10);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
